conv_pe_multilane: RTL and testbench
====================================

// Module: conv_pe_multilane
// PURPOSE
//  Next-generation convolution PE. It performs LANES parallel signed MACs per
//  beat, reduces them in an adder tree and accumulates over a runtime-
//  configurable number of beats (one kernel window). It then emits one partial
//  sum over a valid/ready handshake. It sits in the PE array between the
//  ifmap/filter feeders and the psum collector, replacing the single-lane PE.
// PARAMETERS
//  DATA_WIDTH  16  signed width of each ifmap/filter operand
//  LANES       4   parallel multipliers per beat (>=1, power of 2)
//  ACC_WIDTH   40  signed accumulator/output width (>= 2*DATA_WIDTH+log2(LANES))
//  MULT_LAT    2   multiplier pipeline stages (>=1)
//  CNT_WIDTH   8   width of beat counter / cfg_len
// PORTS
//  clk        in   1                 clock, rising edge
//  rstn       in   1                 asynchronous, active-low reset
//  cfg_len    in   CNT_WIDTH         beats per accumulation group; sampled on first beat
//  cfg_psum_en in  1                 add psum_in to group; sampled on first beat
//  psum_in    in   ACC_WIDTH         incoming partial sum; sampled on first beat
//  in_valid   in   1                 ifmap/fltr beat valid
//  in_ready   out  1                 PE can accept a beat
//  ifmap      in   LANES*DATA_WIDTH  packed signed activations, lane 0 in LSBs
//  fltr       in   LANES*DATA_WIDTH  packed signed weights, lane 0 in LSBs
//  out_valid  out  1                 out_psum valid
//  out_ready  in   1                 downstream accepts out_psum
//  out_psum   out  ACC_WIDTH         accumulated group result
//  ovf        out  1                 overflow occurred in current/last group (sticky)
//  busy       out  1                 state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, all pipeline regs/acc/counter=0. Outputs: in_ready=1,
//    out_valid=0, out_psum=0, ovf=0, busy=0. Reset mid-group discards all work.
//  - FSM: IDLE -> ACC on first accepted beat.
//    ACC -> DRAIN when accepted-beat count reaches len.
//    DRAIN -> HOLD after MULT_LAT+1 cycles.
//    HOLD -> IDLE on out_valid&out_ready.
//  - len = latched cfg_len; cfg_len==0 is treated as 1. A 1-beat group goes
//    IDLE->DRAIN directly.
//  - in_ready=1 in IDLE/ACC, 0 in DRAIN/HOLD. It is registered; there is no
//    combinational path from out_ready.
//  - Beat accepted when in_valid&in_ready. A bubble (in_valid=0) in ACC holds
//    the counter; the pipeline carries a valid bit.
//  - Datapath: per-lane signed DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH product
//    over MULT_LAT stages. Registered adder tree of LANES products,
//    sign-extended to ACC_WIDTH (1 stage).
//  - Accumulate: the first valid sum of a group loads
//    acc = sum + (psum_en ? psum_in_latched : 0); later valid sums do acc += sum.
//  - Latency: last beat accepted at edge t -> out_valid high after edge
//    t+MULT_LAT+2. out_psum is stable while out_valid=1 and out_ready=0.
//  - Output transfer: out_valid&out_ready -> next cycle out_valid=0,
//    in_ready=1, state=IDLE.
//  - Overflow: signed overflow of any accumulate step sets ovf. ovf stays set
//    through HOLD and clears when the next group's first beat is accepted.
//  - Simultaneous: if out_ready is already high when out_valid rises,
//    transfer completes in 1 cycle.
// CONFIGURATION
//  - Macro PE_SAT_EN defined: on overflow acc clamps to
//    +2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1) and stays clamped (further
//    opposite-sign adds continue from the clamp). ovf still set.
//  - Macro PE_SAT_EN undefined: acc wraps modulo 2^ACC_WIDTH; ovf still set.
// TESTING (defaults unless stated)
//  1 cfg_len=9, 9 beats all lanes ifmap=2, fltr=3, psum_en=0
//    -> out_psum=216, out_valid after last beat +MULT_LAT+2 = 4 cycles, ovf=0.
//  2 cfg_len=3, psum_en=1, psum_in=-100, lanes {1,-2,3,-4}x{5,5,5,5} per beat
//    -> out_psum=-100+3*(-10)=-130.
//  3 cfg_len=4 with in_valid low on alternate cycles, out_ready held 0 for
//    10 cycles -> in_ready=0 in DRAIN/HOLD, out_psum held stable, transfer
//    on out_ready=1.
//  4 cfg_len=0, one beat 7x7 on lane0, others 0 -> treated as 1 beat,
//    out_psum=49.
//  5 ACC_WIDTH=33, 4 beats all 16'h7FFF x 16'h7FFF -> ovf=1. With PE_SAT_EN
//    out_psum=2^32-1; without PE_SAT_EN it is the wrapped value.
//  6 rstn pulsed low mid-ACC (beat 5 of 9) -> next cycle in_ready=1,
//    out_valid=0, ovf=0. A fresh 9-beat group gives the correct result.

Source files
------------

// File: rtl/conv_pe_multilane.sv
// conv_pe_multilane: LANES signed MACs per beat, registered adder tree and
// per-group accumulator, psum out over valid/ready. PE_SAT_EN: saturate acc.
// Ports: clk, rstn (async, active-low); cfg_len, cfg_psum_en, psum_in
// (sampled on first beat); in_valid/in_ready with ifmap/fltr (lane 0 LSBs);
// out_valid/out_ready with out_psum; ovf (sticky per group); busy.
module conv_pe_multilane #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 40,
    parameter int MULT_LAT   = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [CNT_WIDTH-1:0]          cfg_len,
    input  logic                          cfg_psum_en,
    input  logic [ACC_WIDTH-1:0]          psum_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   ifmap,
    input  logic [LANES*DATA_WIDTH-1:0]   fltr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          out_psum,
    output logic                          ovf,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;

    localparam int PW  = 2 * DATA_WIDTH;
    localparam int DCW = $clog2(MULT_LAT + 2);
    localparam int MSB = ACC_WIDTH - 1;

    typedef logic signed [PW-1:0]        prod_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;

`ifdef PE_SAT_EN
    localparam acc_t ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] len_eff;
    logic                 pen_q;
    acc_t                 psum_q;
    logic [DCW-1:0]       dcnt;
    logic                 accept;
    logic                 first_beat;

    logic signed [DATA_WIDTH-1:0] op_a [LANES];
    logic signed [DATA_WIDTH-1:0] op_b [LANES];
    prod_t                        mul_q [MULT_LAT][LANES];
    logic [MULT_LAT-1:0]          vld_q;
    logic [MULT_LAT-1:0]          fst_q;

    acc_t tree;
    acc_t tree_q;
    logic tv_q;
    logic tf_q;

    acc_t acc_q;
    acc_t addend;
    acc_t sum_raw;
    acc_t acc_nxt;
    logic step_ovf;

    assign accept     = in_valid & in_ready;
    assign first_beat = accept & (state == IDLE);
    assign len_eff    = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
    assign cnt_inc    = cnt + CNT_WIDTH'(1);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)
                         state_nxt = (len_eff == CNT_WIDTH'(1)) ? DRAIN : ACC;
            ACC:     if (accept && cnt_inc == len_q)
                         state_nxt = DRAIN;
            // wait for the last beat to clear multiplier, tree and acc
            DRAIN:   if (dcnt == DCW'(MULT_LAT + 1))
                         state_nxt = HOLD;
            HOLD:    if (out_valid && out_ready)
                         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            len_q     <= '0;
            pen_q     <= 1'b0;
            psum_q    <= '0;
            dcnt      <= '0;
            out_psum  <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE) || (state_nxt == ACC);
            out_valid <= (state_nxt == HOLD);
            if (first_beat) begin
                len_q  <= len_eff;
                pen_q  <= cfg_psum_en;
                psum_q <= $signed(psum_in);
                cnt    <= CNT_WIDTH'(1);
            end else if (accept) begin
                cnt <= cnt_inc;
            end
            dcnt <= (state == DRAIN) ? dcnt + DCW'(1) : '0;
            if (state == DRAIN && state_nxt == HOLD)
                out_psum <= acc_q;
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            op_a[l] = ifmap[l*DATA_WIDTH +: DATA_WIDTH];
            op_b[l] = fltr[l*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < MULT_LAT; s++)
                for (int l = 0; l < LANES; l++)
                    mul_q[s][l] <= '0;
            vld_q <= '0;
            fst_q <= '0;
        end else begin
            for (int l = 0; l < LANES; l++)
                mul_q[0][l] <= prod_t'(op_a[l]) * prod_t'(op_b[l]);
            vld_q[0] <= accept;
            fst_q[0] <= first_beat;
            for (int s = 1; s < MULT_LAT; s++) begin
                mul_q[s] <= mul_q[s-1];
                vld_q[s] <= vld_q[s-1];
                fst_q[s] <= fst_q[s-1];
            end
        end
    end

    always_comb begin
        tree = '0;
        for (int l = 0; l < LANES; l++)
            tree = tree + acc_t'(mul_q[MULT_LAT-1][l]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tree_q <= '0;
            tv_q   <= 1'b0;
            tf_q   <= 1'b0;
        end else begin
            tree_q <= tree;
            tv_q   <= vld_q[MULT_LAT-1];
            tf_q   <= fst_q[MULT_LAT-1];
        end
    end

    // first sum of a group loads acc (optionally seeded by psum_in)
    always_comb begin
        addend   = tf_q ? (pen_q ? psum_q : '0) : acc_q;
        sum_raw  = addend + tree_q;
        step_ovf = (addend[MSB] == tree_q[MSB]) &&
                   (sum_raw[MSB] != addend[MSB]);
`ifdef PE_SAT_EN
        acc_nxt = step_ovf ? (addend[MSB] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
        acc_nxt = sum_raw;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
            ovf   <= 1'b0;
        end else begin
            if (tv_q)
                acc_q <= acc_nxt;
            if (first_beat)
                ovf <= 1'b0;
            else if (tv_q && step_ovf)
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_pe_multilane.sv
// tb_conv_pe_multilane: randomized + directed groups, arithmetic reference
// model feeding a scoreboard queue, monitor pops on each output transfer.
module tb_conv_pe_multilane;

    localparam int DW = 16;
    localparam int LN = 4;
    localparam int AW = 40;
    localparam int ML = 2;
    localparam int CW = 8;

    localparam longint AMAX = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (AW - 1));
    localparam longint AMOD = longint'(1) <<< AW;

    logic              clk;
    logic              rstn;
    logic [CW-1:0]     cfg_len;
    logic              cfg_psum_en;
    logic [AW-1:0]     psum_in;
    logic              in_valid;
    logic              in_ready;
    logic [LN*DW-1:0]  ifmap;
    logic [LN*DW-1:0]  fltr;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_psum;
    logic              ovf;
    logic              busy;

    conv_pe_multilane #(
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .ACC_WIDTH  (AW),
        .MULT_LAT   (ML),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_len     (cfg_len),
        .cfg_psum_en (cfg_psum_en),
        .psum_in     (psum_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ifmap       (ifmap),
        .fltr        (fltr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_psum    (out_psum),
        .ovf         (ovf),
        .busy        (busy)
    );

    typedef struct {
        logic [AW-1:0] psum;
        bit            ov;
    } req_t;

    req_t    req_q [$];
    shortint ga [256][LN];
    shortint gf [256][LN];
    int      n_cmp = 0;
    int      n_err = 0;
    int      bp_mode = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // group result = psum seed + sum over beats of sum over lanes of a*b,
    // with each running step checked against the signed ACC range
    function automatic void model(input int nb, input bit pen,
                                  input longint pin, output longint res,
                                  output bit ov);
        longint acc;
        longint s;
        longint t;
        ov  = 0;
        acc = pen ? pin : 0;
        for (int b = 0; b < nb; b++) begin
            s = 0;
            for (int l = 0; l < LN; l++)
                s += longint'(ga[b][l]) * longint'(gf[b][l]);
            t = acc + s;
            if (t > AMAX || t < AMIN) begin
                ov = 1;
`ifdef PE_SAT_EN
                t = (t > AMAX) ? AMAX : AMIN;
`else
                t = (t > AMAX) ? t - AMOD : t + AMOD;
`endif
            end
            acc = t;
        end
        res = acc;
    endfunction

    task automatic fill_rand(input int nb, input int mag);
        for (int b = 0; b < nb; b++)
            for (int l = 0; l < LN; l++) begin
                ga[b][l] = shortint'(int'($urandom_range(0, 2*mag)) - mag);
                gf[b][l] = shortint'(int'($urandom_range(0, 2*mag)) - mag);
            end
    endtask

    task automatic fill_const(input int nb, input shortint a,
                              input shortint f);
        for (int b = 0; b < nb; b++)
            for (int l = 0; l < LN; l++) begin
                ga[b][l] = a;
                gf[b][l] = f;
            end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_psum", 64'(out_psum), 64'd0);
        @(negedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
    endtask

    // bub<0: one idle cycle before every beat but the first
    task automatic run_group(input int cfg, input bit pen, input longint pin,
                             input int bub, input int abort_at);
        int          nb;
        int          w;
        longint      r;
        bit          ov;
        req_t        e;
        logic [63:0] rr;
        nb = (cfg == 0) ? 1 : cfg;
        model(nb, pen, pin, r, ov);
        if (abort_at == 0) begin
            e.psum = r[AW-1:0];
            e.ov   = ov;
            req_q.push_back(e);
        end
        for (int b = 0; b < nb; b++) begin
            if (abort_at != 0 && b == abort_at) begin
                pulse_reset();
                return;
            end
            @(negedge clk);
            if (bub < 0) begin
                if (b > 0) @(negedge clk);
            end else begin
                while (int'($urandom_range(0, 99)) < bub) @(negedge clk);
            end
            for (int l = 0; l < LN; l++) begin
                ifmap[l*DW +: DW] = ga[b][l];
                fltr[l*DW +: DW]  = gf[b][l];
            end
            if (b == 0) begin
                cfg_len     = CW'(cfg);
                cfg_psum_en = pen;
                psum_in     = pin[AW-1:0];
            end else begin
                rr          = {$urandom, $urandom};
                cfg_len     = CW'($urandom);
                cfg_psum_en = ($urandom_range(0, 1) != 0);
                psum_in     = rr[AW-1:0];
            end
            in_valid = 1'b1;
            w = 0;
            while (!in_ready && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                n_cmp++;
                n_err++;
                $display("FAIL in_ready_timeout actual=0 required=1");
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_empty(input int bound);
        int n;
        n = 0;
        while (req_q.size() > 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (req_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout actual=%0d required=0", req_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [AW-1:0] prev;
        bit            hold;
        req_t          e;
        hold = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                hold = 0;
                continue;
            end
            if (hold) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_psum !== prev) begin
                    n_err++;
                    $display("FAIL hold_stable actual=%0b/%0h required=1/%0h",
                             out_valid, out_psum, prev);
                end
            end
            hold = out_valid && !out_ready;
            prev = out_psum;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (req_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out actual=%0h required=none",
                             out_psum);
                end else begin
                    e = req_q.pop_front();
                    if (out_psum !== e.psum || ovf !== e.ov) begin
                        n_err++;
                        $display("FAIL scoreboard actual=%0h/%0b required=%0h/%0b",
                                 out_psum, ovf, e.psum, e.ov);
                    end
                end
            end
        end
    end

    initial begin : stim
        int n;
        bit pen;
        longint pin;
        logic [63:0] rr;
        logic signed [AW-1:0] ps;
        rstn        = 1'b0;
        in_valid    = 1'b0;
        cfg_len     = '0;
        cfg_psum_en = 1'b0;
        psum_in     = '0;
        ifmap       = '0;
        fltr        = '0;
        #12;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_psum", 64'(out_psum), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        fill_const(9, 2, 3);
        run_group(9, 0, 0, 0, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t1_latency", 64'(n), 64'(ML + 2));
        @(posedge clk);
        #1;
        chk("t1_xfer_valid", 64'(out_valid), 64'd0);
        chk("t1_xfer_in_ready", 64'(in_ready), 64'd1);
        chk("t1_xfer_busy", 64'(busy), 64'd0);
        wait_empty(50);

        for (int b = 0; b < 3; b++) begin
            ga[b][0] = 1;
            ga[b][1] = -2;
            ga[b][2] = 3;
            ga[b][3] = -4;
            for (int l = 0; l < LN; l++) gf[b][l] = 5;
        end
        run_group(3, 1, -100, 0, 0);
        wait_empty(50);

        fill_rand(1, 1000);
        ga[0][0] = 7;
        gf[0][0] = 7;
        for (int l = 1; l < LN; l++) ga[0][l] = 0;
        run_group(0, 0, 0, 0, 0);
        wait_empty(50);

        bp_mode = 2;
        @(posedge clk);
        fill_rand(4, 3000);
        run_group(4, 1, 12345, -1, 0);
        chk("t3_in_ready_drain", 64'(in_ready), 64'd0);
        chk("t3_busy_drain", 64'(busy), 64'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("t3_in_ready_hold", 64'(in_ready), 64'd0);
            chk("t3_valid_hold", 64'(out_valid), 64'd1);
        end
        bp_mode = 0;
        wait_empty(50);

        fill_const(4, 16'sh7FFF, 16'sh7FFF);
        run_group(4, 1, AMAX - (longint'(1) <<< 33), 0, 0);
        wait_empty(50);
        fill_const(3, 16'sh7FFF, -16'sh8000);
        run_group(3, 1, AMIN + 5, 0, 0);
        wait_empty(50);
        chk("ovf_sticky_idle", 64'(ovf), 64'd1);

        fill_rand(9, 30000);
        run_group(9, 1, 777, 0, 5);
        fill_const(9, 2, 3);
        run_group(9, 0, 0, 0, 0);
        wait_empty(50);

        fill_const(200, -16'sh8000, -16'sh8000);
        run_group(200, 0, 0, 0, 0);
        wait_empty(50);

        bp_mode = 1;
        for (int g = 0; g < 30; g++) begin
            pen = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 3) == 0) begin
                rr  = {$urandom, $urandom};
                ps  = rr[AW-1:0];
                pin = longint'(ps);
            end else begin
                pin = longint'($urandom_range(0, 2000)) - 1000;
            end
            fill_rand(12, 32767);
            run_group(int'($urandom_range(0, 12)), pen, pin, 30, 0);
        end
        bp_mode = 0;
        wait_empty(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
